if_id_queue: RTL



---
 rtl/if_id_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Instruction buffer between IF and ID: a DEPTH-entry FIFO of {inst, pc, exc} with flush
// support and an exception fence that stops further fetch once a faulting entry is queued.
module if_id_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned INST_W   = 32,
    parameter int unsigned EXC_W    = 6,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000033
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fs_to_ds_valid,
    input  logic [INST_W+PC_W-1:0]    if_id_bus_in,
    input  logic [EXC_W-1:0]          exception_code_fd,
    output logic                      ds_allowin,
    input  logic                      flush,
    input  logic                      exc_flush,
    input  logic                      ds_ready_go,
    input  logic                      es_allowin,
    output logic                      head_valid,
    output logic [INST_W+PC_W-1:0]    head_bus,
    output logic [EXC_W-1:0]          head_exc,
    output logic                      ds_to_es_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      fenced
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = INST_W + PC_W;
    localparam int unsigned EW = BW + EXC_W;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fenced_q, fenced_d;

    logic          flush_any;
    logic          pop;
    logic          push;
    logic [EW-1:0] head_entry;

    always_comb begin
        flush_any  = flush | exc_flush;
        head_valid = (count_q != '0);
        pop        = head_valid && ds_ready_go && es_allowin;
        // Acceptance is not gated by flush; the entry is simply dropped below.
        ds_allowin = !fenced_q && ((count_q < CW'(DEPTH)) || pop);
        push       = fs_to_ds_valid && ds_allowin;
    end

    always_comb begin
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        fenced_d = fenced_q;
        if (flush_any) begin
            rptr_d   = '0;
            wptr_d   = '0;
            count_d  = '0;
            fenced_d = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
                if (exception_code_fd[EXC_W-1]) begin
                    fenced_d = 1'b1;
                end
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            fenced_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            fenced_q <= fenced_d;
            if (push && !flush_any) begin
                mem_q[wptr_q] <= {if_id_bus_in, exception_code_fd};
            end
        end
    end

    always_comb begin
        head_entry     = mem_q[rptr_q];
        head_bus       = head_valid ? head_entry[EW-1:EXC_W] : {NOP_INST, {PC_W{1'b0}}};
        head_exc       = head_valid ? head_entry[EXC_W-1:0] : '0;
        ds_to_es_valid = head_valid && ds_ready_go;
        count          = count_q;
        fenced         = fenced_q;
    end

    assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n) fenced_q |-> !ds_allowin);
    assert property (@(posedge clk) disable iff (!rst_n) (count_q == '0) |-> !pop);

endmodule
